// File: rtl/uart_pkg.sv
// Shared constants and types for the uart block and its byte-level clients.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: default clock/baud, command opcodes and reply bytes, the
// responder FSM encoding, the TX handshake encoding, and a saturating
// increment helper for 8-bit event counters.
package uart_pkg;

  // Default system clock and line rate, shared with the uart block.
  localparam int CLK_HZ          = 27_000_000;
  localparam int BAUD            = 115_200;
  // One second of inter-byte silence at the default clock.
  localparam int TIMEOUT_DEFAULT = CLK_HZ;

  // Host command opcodes and responder reply bytes (ASCII).
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RPL_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_ERR   = 8'h3F;  // '?'

  // Command decode FSM of the register responder.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WRITE,
    ST_BUS_READ,
    ST_TX_START,
    ST_TX_WAIT_LOW,
    ST_TX_WAIT_HIGH
  } rsp_state_e;

  // TX handshake phases. TX_IDLE with send_i high is the "start" cycle.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOW,
    TX_HIGH
  } tx_state_e;

  // Increment that sticks at 0xFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sender.sv
// Sends one byte through the uart TX trigger/complete handshake.
// Latency: tx_trigger_o rises in the same cycle as send_i; done_o pulses the cycle tx_complete_i is seen high again.
// Backpressure: send_i is honoured only when idle; trigger is held until the uart reports busy, so no byte is lost or repeated.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   send_i            one-cycle request, sampled only in TX_IDLE
//   byte_i            byte to send, captured with send_i
//   tx_complete_i     uart TX idle (1) / busy (0)
//   tx_data_o         byte to the uart, held until the next send
//   tx_trigger_o      send request to the uart
//   done_o            one-cycle pulse when the uart has finished the byte
module uart_tx_sender
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       send_i,
  input  logic [7:0] byte_i,
  input  logic       tx_complete_i,
  output logic [7:0] tx_data_o,
  output logic       tx_trigger_o,
  output logic       done_o
);

  tx_state_e  st_q, st_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    st_d         = st_q;
    byte_d       = byte_q;
    tx_data_o    = byte_q;
    tx_trigger_o = 1'b0;
    done_o       = 1'b0;

    unique case (st_q)
      TX_IDLE: begin
        if (send_i) begin
          // The uart may sample data on the very cycle the trigger rises,
          // so the new byte is passed straight through before it lands in byte_q.
          byte_d       = byte_i;
          tx_data_o    = byte_i;
          tx_trigger_o = 1'b1;
          st_d         = TX_LOW;
        end
      end
      TX_LOW: begin
        // Keep requesting until the uart shows it has taken the byte.
        tx_trigger_o = 1'b1;
        if (!tx_complete_i) begin
          st_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        if (tx_complete_i) begin
          done_o = 1'b1;
          st_d   = TX_IDLE;
        end
      end
      default: begin
        st_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= TX_IDLE;
      byte_q <= 8'h00;
    end else begin
      st_q   <= st_d;
      byte_q <= byte_d;
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// Decodes 'W' addr data / 'R' addr commands from uart RX bytes into one register-bus access and a one-byte reply.
// Latency: write strobe 1 cycle after the data byte, read sampled 1 cycle after the addr byte, reply trigger 1 cycle after that.
// Backpressure: none on RX (bytes arriving while busy are dropped and counted); TX waits on the uart complete handshake.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   rx_byte_ready_i    uart RX level; rising edge marks a new byte in rx_data_i
//   tx_data_o          reply byte, held until the next reply starts
//   tx_trigger_o       reply send request
//   tx_complete_i      uart TX idle (1) / busy (0)
//   bus_addr_o         register address (ADDR_W bits, ADDR_W <= 8)
//   bus_wdata_o        register write data
//   bus_we_o           one-cycle write strobe
//   bus_rdata_i        register read data, combinational from bus_addr_o
//   busy_o             high whenever a command or reply is in progress
//   err_count_o        saturating count of protocol errors
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_byte_ready_i,
  input  logic [7:0]        rx_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_trigger_o,
  input  logic              tx_complete_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  output logic              bus_we_o,
  input  logic [7:0]        bus_rdata_i,
  output logic              busy_o,
  output logic [7:0]        err_count_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  rsp_state_e        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        reply_q, reply_d;
  logic [7:0]        err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic new_byte;
  logic addr_ok;
  logic send;
  logic tx_done;

  // rdy_q comes out of reset high, so a byte already pending then is not
  // mistaken for a fresh rising edge.
  assign new_byte = rx_byte_ready_i & ~rdy_q;

  // Any address bit above the bus width makes the command invalid.
  assign addr_ok  = ((rx_data_i >> ADDR_W) == 8'd0);

  always_comb begin
    state_d  = state_q;
    rdy_d    = rx_byte_ready_i;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    reply_d  = reply_q;
    err_d    = err_q;
    // The inter-byte counter is zero outside the receive states, which
    // also restarts it on every entry into GET_ADDR / GET_DATA.
    tmo_d    = '0;
    send     = 1'b0;
    bus_we_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (new_byte) begin
          if ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)) begin
            is_wr_d = (rx_data_i == CMD_WRITE);
            state_d = ST_GET_ADDR;
          end else begin
            reply_d = RPL_ERR;
            err_d   = sat_inc8(err_q);
            state_d = ST_TX_START;
          end
        end
      end

      ST_GET_ADDR: begin
        // A byte landing on the timeout cycle still counts as in time.
        if (new_byte) begin
          if (addr_ok) begin
            addr_d  = rx_data_i[ADDR_W-1:0];
            state_d = is_wr_q ? ST_GET_DATA : ST_BUS_READ;
          end else begin
            reply_d = RPL_ERR;
            err_d   = sat_inc8(err_q);
            state_d = ST_TX_START;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_GET_DATA: begin
        if (new_byte) begin
          wdata_d = rx_data_i;
          state_d = ST_BUS_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = sat_inc8(err_q);
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_BUS_WRITE: begin
        bus_we_o = 1'b1;
        reply_d  = RPL_ACK;
        state_d  = ST_TX_START;
      end

      ST_BUS_READ: begin
        // bus_addr_o has been stable for a full cycle by now.
        reply_d = bus_rdata_i;
        state_d = ST_TX_START;
      end

      ST_TX_START: begin
        send    = 1'b1;
        state_d = ST_TX_WAIT_LOW;
      end

      // The two wait states track the sender's own phases on the same
      // input, so the two FSMs step together.
      ST_TX_WAIT_LOW: begin
        if (!tx_complete_i) begin
          state_d = ST_TX_WAIT_HIGH;
        end
      end

      ST_TX_WAIT_HIGH: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bytes that arrive while an access or reply is in progress are lost.
    if (new_byte && (state_q inside {ST_BUS_WRITE, ST_BUS_READ, ST_TX_START,
                                     ST_TX_WAIT_LOW, ST_TX_WAIT_HIGH})) begin
      err_d = sat_inc8(err_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      reply_q <= 8'h00;
      err_q   <= 8'h00;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      reply_q <= reply_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  uart_tx_sender u_tx_sender (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .send_i        (send),
    .byte_i        (reply_q),
    .tx_complete_i (tx_complete_i),
    .tx_data_o     (tx_data_o),
    .tx_trigger_o  (tx_trigger_o),
    .done_o        (tx_done)
  );

  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_count_o = err_q;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with a small uart TX model and register file.
// Latency: n/a (testbench).
// Backpressure: the uart model stays idle 3 cycles after a trigger, then busy 4 cycles.
module tb_uart_reg_responder;

  logic       clk;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_trigger;
  logic       tx_complete;
  logic [3:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic [7:0] bus_rdata;
  logic       busy;
  logic [7:0] err_count;

  logic [7:0] mem [16];
  assign bus_rdata = mem[bus_addr];

  int n_chk = 0;
  int n_bad = 0;

  // Monitor state
  int         sent_cnt = 0;
  logic [7:0] sent_byte = 8'h00;
  int         trig_cyc = 0;
  int         we_cnt = 0;
  logic [3:0] we_addr = 4'h0;
  logic [7:0] we_data = 8'h00;

  int sent0, trig0, we0;

  uart_reg_responder #(
    .ADDR_W         (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_byte_ready_i (rx_rdy),
    .rx_data_i       (rx_data),
    .tx_data_o       (tx_data),
    .tx_trigger_o    (tx_trigger),
    .tx_complete_i   (tx_complete),
    .bus_addr_o      (bus_addr),
    .bus_wdata_o     (bus_wdata),
    .bus_we_o        (bus_we),
    .bus_rdata_i     (bus_rdata),
    .busy_o          (busy),
    .err_count_o     (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart TX model: takes the byte when it sees a trigger while idle, stays
  // idle-looking for 3 more cycles, then busy for 4 cycles.
  initial begin
    tx_complete = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_trigger && tx_complete) begin
        sent_cnt++;
        sent_byte = tx_data;
        repeat (3) @(posedge clk);
        #1 tx_complete = 1'b0;
        repeat (4) @(posedge clk);
        #1 tx_complete = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (tx_trigger) trig_cyc++;
    if (bus_we) begin
      we_cnt++;
      we_addr = bus_addr;
      we_data = bus_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise ready with a new byte; returns inside the cycle of the edge.
  task automatic put_byte(input logic [7:0] b);
    tick();
    rx_data = b;
    rx_rdy  = 1'b1;
  endtask

  // Full byte: edge, then ready drops one cycle later.
  task automatic send(input logic [7:0] b);
    put_byte(b);
    tick();
    rx_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk(tag, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[3] = 8'hA5;

    // Reset with a byte already pending on the RX side.
    rst     = 1'b1;
    rx_rdy  = 1'b1;
    rx_data = 8'h41;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_trig",  tx_trigger, 0);
    chk("rst_we",    bus_we, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_txd",   tx_data, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_err",   err_count, 0);
    chk("rst_addr",  bus_addr, 0);
    repeat (5) tick();
    chk("pend_busy", busy, 0);
    chk("pend_err",  err_count, 0);
    rx_rdy = 1'b0;
    tick();

    // Read R, 0x03
    send(8'h52);
    sent0 = sent_cnt; trig0 = trig_cyc; we0 = we_cnt;
    put_byte(8'h03);
    chk("rd_busy", busy, 1);
    tick(); rx_rdy = 1'b0;
    chk("rd_addr",   bus_addr, 3);
    chk("rd_trig_1", tx_trigger, 0);
    tick();
    chk("rd_trig_2", tx_trigger, 1);
    chk("rd_txd",    tx_data, 8'hA5);
    wait_idle("rd_idle");
    chk("rd_sent",   sent_cnt - sent0, 1);
    chk("rd_byte",   sent_byte, 8'hA5);
    chk("rd_no_we",  we_cnt - we0, 0);
    chk("rd_trig_n", trig_cyc - trig0, 4);
    chk("rd_hold",   tx_data, 8'hA5);

    // Write W, 0x0F, 0x5C
    send(8'h57);
    send(8'h0F);
    we0 = we_cnt; sent0 = sent_cnt;
    put_byte(8'h5C);
    tick(); rx_rdy = 1'b0;
    chk("wr_we",    bus_we, 1);
    chk("wr_addr",  bus_addr, 4'hF);
    chk("wr_wdata", bus_wdata, 8'h5C);
    tick();
    chk("wr_we_off", bus_we, 0);
    chk("wr_trig",   tx_trigger, 1);
    chk("wr_txd",    tx_data, 8'h4B);
    wait_idle("wr_idle");
    chk("wr_cmpl_hi", tx_complete, 1);
    chk("wr_we_n",    we_cnt - we0, 1);
    chk("wr_we_addr", we_addr, 4'hF);
    chk("wr_we_data", we_data, 8'h5C);
    chk("wr_sent",    sent_cnt - sent0, 1);
    chk("wr_byte",    sent_byte, 8'h4B);

    // Unknown opcode, then invalid address
    put_byte(8'h41);
    tick(); rx_rdy = 1'b0;
    chk("op_trig", tx_trigger, 1);
    chk("op_txd",  tx_data, 8'h3F);
    chk("op_err",  err_count, 1);
    wait_idle("op_idle");
    send(8'h52);
    put_byte(8'h10);
    tick(); rx_rdy = 1'b0;
    chk("ad_trig", tx_trigger, 1);
    chk("ad_txd",  tx_data, 8'h3F);
    chk("ad_err",  err_count, 2);
    wait_idle("ad_idle");
    chk("ad_byte", sent_byte, 8'h3F);

    // Byte arriving during the reply is dropped and counted
    sent0 = sent_cnt; trig0 = trig_cyc;
    send(8'h52);
    put_byte(8'h03);
    tick(); rx_rdy = 1'b0;
    tick();
    put_byte(8'h99);
    tick(); rx_rdy = 1'b0;
    chk("drop_err", err_count, 3);
    wait_idle("drop_idle");
    chk("drop_sent",   sent_cnt - sent0, 1);
    chk("drop_byte",   sent_byte, 8'hA5);
    chk("drop_trig_n", trig_cyc - trig0, 4);

    // Timeout in GET_DATA
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_err", err_count, 0);
    sent0 = sent_cnt; we0 = we_cnt;
    send(8'h57);
    put_byte(8'h02);
    tick(); rx_rdy = 1'b0;
    repeat (99) tick();
    chk("tmo_busy_pre", busy, 1);
    tick();
    chk("tmo_busy", busy, 0);
    chk("tmo_err",  err_count, 1);
    chk("tmo_sent", sent_cnt - sent0, 0);
    chk("tmo_we",   we_cnt - we0, 0);

    // Data byte on the exact timeout cycle wins
    send(8'h57);
    put_byte(8'h02);
    tick(); rx_rdy = 1'b0;
    repeat (98) tick();
    put_byte(8'h77);
    tick(); rx_rdy = 1'b0;
    chk("race_we",    bus_we, 1);
    chk("race_wdata", bus_wdata, 8'h77);
    chk("race_err",   err_count, 1);
    wait_idle("race_idle");
    chk("race_byte",  sent_byte, 8'h4B);

    // Reset in GET_DATA
    send(8'h57);
    send(8'h05);
    chk("rgd_busy_pre", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rgd_busy",  busy, 0);
    chk("rgd_addr",  bus_addr, 0);
    chk("rgd_wdata", bus_wdata, 0);
    chk("rgd_err",   err_count, 0);
    chk("rgd_txd",   tx_data, 0);
    chk("rgd_trig",  tx_trigger, 0);
    send(8'h52);
    put_byte(8'h03);
    tick(); rx_rdy = 1'b0;
    tick();
    chk("rgd_rd_trig", tx_trigger, 1);
    chk("rgd_rd_txd",  tx_data, 8'hA5);
    wait_idle("rgd_idle");

    // Reset in TX_WAIT_HIGH
    send(8'h52);
    send(8'h03);
    for (int i = 0; i < 50 && !(tx_complete == 1'b0 && tx_trigger == 1'b0); i++) tick();
    chk("rwh_reach", {tx_trigger, tx_complete, busy}, 3'b001);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rwh_trig", tx_trigger, 0);
    chk("rwh_busy", busy, 0);
    chk("rwh_txd",  tx_data, 0);
    for (int i = 0; i < 50 && !tx_complete; i++) tick();
    chk("rwh_cmpl", tx_complete, 1);
    sent0 = sent_cnt;
    send(8'h52);
    put_byte(8'h03);
    tick(); rx_rdy = 1'b0;
    tick();
    chk("rwh_rd_trig", tx_trigger, 1);
    chk("rwh_rd_txd",  tx_data, 8'hA5);
    wait_idle("rwh_idle");
    chk("rwh_sent", sent_cnt - sent0, 1);
    chk("rwh_byte", sent_byte, 8'hA5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder sitting on the far side of the `uart` block. It consumes received bytes (`rx_byte_ready`/`rx_data`), decodes a 2- or 3-byte read/write command from the host PC, and performs one access on a small register bus. It then answers with one byte through the `uart` TX handshake (`tx_data`/`tx_trigger`/`tx_complete`). It turns the raw serial link into a debug register port for the rest of the design.

## Interface
- `ADDR_W`, 4: register bus address width; addresses 0..2^ADDR_W-1.
- `TIMEOUT_CYCLES`, 27_000_000: idle cycles allowed between bytes of one command (1 s at 27 MHz).

- `clk_i` in 1: system clock.
- `rst_i` in 1: synchronous, active-high reset.
- `rx_byte_ready_i` in 1: level from `uart`; a rising edge marks a new byte.
- `rx_data_i` in 8: received byte, valid when `rx_byte_ready_i` is high.
- `tx_data_o` out 8: byte to send. Held stable for the whole transmission because `uart` samples it per bit.
- `tx_trigger_o` out 1: send request.
- `tx_complete_i` in 1: `uart` TX idle (1) / busy (0).
- `bus_addr_o` out ADDR_W: register address.
- `bus_wdata_o` out 8: write data.
- `bus_we_o` out 1: one-cycle write strobe.
- `bus_rdata_i` in 8: read data, combinational from `bus_addr_o`.
- `busy_o` out 1: high whenever the FSM is not IDLE.
- `err_count_o` out 8: saturating protocol-error counter.

## Operation
- Protocol: `W`(0x57) addr data → reply `K`(0x4B). `R`(0x52) addr → reply the register value. Any other opcode, or an addr byte with bits above ADDR_W-1 set → reply `?`(0x3F).
- Byte detect: `new_byte = rx_byte_ready_i & ~rdy_q`. `rdy_q` resets to 1, so a byte already pending at reset is ignored.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS_WRITE, BUS_READ, TX_START, TX_WAIT_LOW, TX_WAIT_HIGH.
- IDLE:
  - `W` or `R` → GET_ADDR, with the opcode latched.
  - Other byte → TX_START with `?`, and `err_count_o` increments.
- GET_ADDR:
  - Valid addr → latch `bus_addr_o`. Then go to GET_DATA (W) or BUS_READ (R).
  - Invalid addr → TX_START with `?`, and `err_count_o` increments.
- GET_DATA: on byte → latch `bus_wdata_o` → BUS_WRITE.
- BUS_WRITE: `bus_we_o` = 1 for exactly this cycle → TX_START with `K`.
- BUS_READ: sample `bus_rdata_i` into the reply register → TX_START.
- TX_START: drive `tx_data_o`, assert `tx_trigger_o`, go to TX_WAIT_LOW.
- TX_WAIT_LOW: hold `tx_trigger_o` until `tx_complete_i` = 0. Then deassert it and go to TX_WAIT_HIGH.
- TX_WAIT_HIGH: wait for `tx_complete_i` = 1, then go to IDLE. `tx_data_o` holds its value until the next TX_START.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA, and clears on each new byte and on state entry.
  - Reaching TIMEOUT_CYCLES-1 → IDLE with no reply, and `err_count_o` increments.
- Bytes arriving in BUS_*/TX_* states are dropped, and each one increments `err_count_o`.
- `err_count_o` saturates at 255 and never wraps.
- If a timeout and a new byte occur in the same cycle, the byte wins.
- Reset values:
  - `tx_trigger_o`, `bus_we_o`, `busy_o`: 0.
  - `tx_data_o`, `bus_wdata_o`, `err_count_o`: 0x00.
  - `bus_addr_o`: 0.
  - State: IDLE.
- Reset mid-transmission: all outputs return to reset values immediately. The byte already in flight in `uart` completes on its own, and the responder ignores it.

## Timing
- Write: final data-byte edge at cycle N → `bus_we_o` = 1 at N+1 → `tx_trigger_o` = 1 from N+2.
- Read: addr-byte edge at N → `bus_rdata_i` sampled at N+1 (address has been stable for 1 cycle) → `tx_trigger_o` from N+2.
- Error reply: offending-byte edge at N → `tx_trigger_o` from N+1.
- `tx_trigger_o` stays high until the first cycle after `tx_complete_i` is seen low. It is never high while `uart` is back in idle, so no double send occurs.
- One reply per command. The next command is accepted only after `tx_complete_i` returns high.

## Structure
- Shared package `uart_pkg`:
  - Opcode/reply constants: `W`, `R`, `K`, `?`.
  - FSM state encoding.
  - Default baud and clock constants, shared with `uart`.
- Sub-module `uart_tx_sender`: the TX_START/WAIT_LOW/WAIT_HIGH handshake, with `send_i`, `byte_i` and `done_o`. This handshake is reusable by any other `uart` client.
- Top-level `uart_reg_responder` holds the decode FSM, timeout counter and error counter.

## Test plan
- `R`, 0x03 with `bus_rdata_i` = 0xA5 at addr 3 → `bus_addr_o` = 3, reply 0xA5 with trigger 2 cycles after the addr edge, `bus_we_o` never asserted.
- `W`, 0x0F, 0x5C → one `bus_we_o` pulse with addr 0xF and data 0x5C, reply 0x4B, `busy_o` low after `tx_complete_i` rises.
- Byte 0x41 → reply 0x3F and `err_count_o` = 1. `R`, 0x10 → reply 0x3F and `err_count_o` = 2.
- `W`, 0x02, then silence for TIMEOUT_CYCLES (test value 100) → IDLE, no reply, no write, `err_count_o` = 1. A timeout coinciding with a byte edge → the byte is accepted.
- Model `uart` holding `tx_complete_i` high for 3 cycles after trigger → trigger held 4 cycles, exactly one byte sent. Extra RX bytes during TX → dropped and counted. `rx_byte_ready_i` already high at reset release → ignored.
- Assert `rst_i` in GET_DATA and in TX_WAIT_HIGH → all outputs at reset values on the next cycle, and a following `R` command works normally.
